// File: rtl/gru_run_ctrl.sv
// gru_run_ctrl: collects streamed feature words into a timestep window, launches the GRU model
// and hands its prediction downstream, with a watchdog on the model's completion.
module gru_run_ctrl #(
  parameter int DATA_W      = 32,
  parameter int N_FEAT      = 3,
  parameter int N_STEPS     = 7,
  parameter int SLIDE       = 1,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [DATA_W-1:0]                  s_data,
  output logic                               o_start_model,
  input  logic                               i_model_done,
  output logic [N_STEPS*N_FEAT*DATA_W-1:0]   o_seq_flat,
  input  logic [DATA_W-1:0]                  i_prediction,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [DATA_W-1:0]                  m_data,
  output logic                               o_busy,
  output logic                               o_timeout,
  output logic [15:0]                        o_run_count
);
  localparam int TOT = N_STEPS * N_FEAT;
  localparam int FW  = $clog2(N_FEAT + 1);
  localparam int SW  = $clog2(N_STEPS + 1);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;
  logic [1:0]            state;
  logic [FW-1:0]         f_cnt;
  logic [SW-1:0]         fill_cnt;
  logic [SW-1:0]         fill_inc;
  logic [TW-1:0]         timer;
  logic [TOT*DATA_W-1:0] win;
  logic                  m_vld;
  logic                  acc;
  logic                  f_wrap;
  logic                  fill_last;
  logic                  t_exp;
  assign acc       = s_valid && s_ready;
  assign f_wrap    = f_cnt == FW'(N_FEAT - 1);
  assign fill_inc  = fill_cnt == SW'(N_STEPS) ? fill_cnt : fill_cnt + 1'b1;
  assign fill_last = f_wrap && fill_inc == SW'(N_STEPS);
  assign t_exp     = timer == TW'(TIMEOUT_CYC - 1);
  // Control outputs are forced low while reset is held, not just after the reset edge.
  assign s_ready       = rstn && state == FILL;
  assign o_start_model = rstn && state == START;
  assign o_busy        = rstn && state != FILL;
  assign o_timeout     = rstn && state == WAIT && t_exp && !i_model_done;
  assign m_valid       = rstn && m_vld;
  assign o_seq_flat    = win;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= FILL;
      win         <= '0;
      f_cnt       <= '0;
      fill_cnt    <= '0;
      timer       <= '0;
      o_run_count <= '0;
      m_data      <= '0;
      m_vld       <= 1'b0;
    end else begin
      if (acc) begin
        win   <= {s_data, win[TOT*DATA_W-1:DATA_W]};
        f_cnt <= f_wrap ? '0 : f_cnt + 1'b1;
        if (f_wrap) fill_cnt <= fill_inc;
      end
      case (state)
        FILL: if (acc && fill_last) state <= START;
        START: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A completion arriving on the last allowed cycle still counts.
          if (i_model_done) begin
            m_data <= i_prediction;
            m_vld  <= 1'b1;
            state  <= OUT;
          end else if (t_exp) begin
            fill_cnt <= '0;
            f_cnt    <= '0;
            state    <= FILL;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: if (m_ready) begin
          m_vld       <= 1'b0;
          o_run_count <= o_run_count + 1'b1;
          fill_cnt    <= SLIDE != 0 ? SW'(N_STEPS - 1) : '0;
          f_cnt       <= '0;
          state       <= FILL;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gru_run_ctrl.sv
// tb_gru_run_ctrl: randomized runs against a queue-based window model, scoreboarded start windows
// and predictions, plus a block-window instance exercised with a directed sequence.
module tb_gru_run_ctrl;
  localparam int DW = 32, NF = 3, NS = 7, TOT = NF * NS, TO = 100;
  logic clk = 1'b0, rstn = 1'b0;
  logic s_valid = 1'b0, i_model_done = 1'b0, m_ready = 1'b0;
  logic [DW-1:0] s_data = '0, i_prediction = '0;
  logic s_ready, o_start_model, m_valid, o_busy, o_timeout;
  logic [TOT*DW-1:0] o_seq_flat;
  logic [DW-1:0] m_data;
  logic [15:0] o_run_count;
  logic b_valid = 1'b0, b_done = 1'b0, b_mready = 1'b0;
  logic [DW-1:0] b_data = '0, b_pred = '0, b_last = '0;
  logic b_sready, b_start, b_mvalid, b_busy, b_timeout;
  logic [TOT*DW-1:0] b_flat;
  logic [DW-1:0] b_mdata;
  logic [15:0] b_runs;
  int checks = 0, errors = 0;
  int need, runs;
  logic [DW-1:0] mwin[$];
  logic [DW-1:0] pred_q[$];
  logic [TOT*DW-1:0] start_q[$];

  gru_run_ctrl #(.DATA_W(DW), .N_FEAT(NF), .N_STEPS(NS), .SLIDE(1), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .o_start_model(o_start_model), .i_model_done(i_model_done), .o_seq_flat(o_seq_flat),
    .i_prediction(i_prediction), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .o_busy(o_busy), .o_timeout(o_timeout), .o_run_count(o_run_count));

  gru_run_ctrl #(.DATA_W(DW), .N_FEAT(NF), .N_STEPS(NS), .SLIDE(0), .TIMEOUT_CYC(TO)) u_blk (
    .clk(clk), .rstn(rstn), .s_valid(b_valid), .s_ready(b_sready), .s_data(b_data),
    .o_start_model(b_start), .i_model_done(b_done), .o_seq_flat(b_flat),
    .i_prediction(b_pred), .m_valid(b_mvalid), .m_ready(b_mready), .m_data(b_mdata),
    .o_busy(b_busy), .o_timeout(b_timeout), .o_run_count(b_runs));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [TOT*DW-1:0] flat();
    logic [TOT*DW-1:0] w;
    for (int k = 0; k < TOT; k++) w[k*DW +: DW] = mwin[k];
    return w;
  endfunction

  task automatic model_reset();
    mwin.delete();
    repeat (TOT) mwin.push_back('0);
    need = TOT;
    runs = 0;
  endtask

  task automatic junk();
    i_model_done = 1'($urandom_range(0, 1));
    i_prediction = $urandom;
  endtask

  task automatic send(input logic [DW-1:0] d, input int idle);
    logic [DW-1:0] old;
    repeat (idle) begin
      @(negedge clk); s_valid = 1'b0; junk();
    end
    @(negedge clk); s_valid = 1'b1; s_data = d; junk(); #1;
    chk("s_ready_fill", s_ready, 1);
    @(posedge clk);
    mwin.push_back(d);
    old = mwin.pop_front();
    need--;
    if (need == 0) start_q.push_back(flat());
  endtask

  task automatic fill(input int n, input int kind, input int idle_max);
    for (int i = 0; i < n; i++)
      send(kind == 0 ? $urandom : kind == 1 ? 32'h3F800000 : 32'(i + 1), $urandom_range(0, idle_max));
  endtask

  task automatic expect_start();
    @(negedge clk); s_valid = 1'b0; junk(); #1;
    chk("start_pulse", o_start_model, 1);
    chk("s_ready_start", s_ready, 0);
    chk("busy_start", o_busy, 1);
  endtask

  task automatic finish_run(input int d, input int stall, input logic [DW-1:0] p);
    for (int c = 1; c <= d; c++) begin
      @(negedge clk); i_model_done = c == d; i_prediction = c == d ? p : $urandom; #1;
      if (c == 1) chk("start_one_cycle", o_start_model, 0);
    end
    chk("done_beats_timeout", o_timeout, 0);
    pred_q.push_back(p);
    for (int s = 0; s <= stall; s++) begin
      @(negedge clk); m_ready = s == stall; junk(); #1;
      chk("m_valid_out", m_valid, 1);
      chk("s_ready_out", s_ready, 0);
    end
    @(negedge clk); m_ready = 1'($urandom_range(0, 1)); junk(); #1;
    runs++;
    need = NF;
    chk("m_valid_drop", m_valid, 0);
    chk("run_count", o_run_count, runs);
    chk("s_ready_back", s_ready, 1);
  endtask

  task automatic timeout_run();
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk); i_model_done = 1'b0; #1;
      if (c == TO - 1) chk("no_early_timeout", o_timeout, 0);
      if (c == TO) begin
        chk("timeout_pulse", o_timeout, 1);
        chk("m_valid_timeout", m_valid, 0);
      end
    end
    @(negedge clk); junk(); #1;
    chk("timeout_one_cycle", o_timeout, 0);
    chk("s_ready_after_to", s_ready, 1);
    chk("runs_after_to", o_run_count, runs);
    need = TOT;
  endtask

  task automatic bsend(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); b_valid = 1'b1; b_data = $urandom; b_last = b_data;
    end
    @(negedge clk); b_valid = 1'b0; #1;
  endtask

  task automatic blk_test();
    bsend(TOT);
    chk("blk_start", b_start, 1);
    chk("blk_window_top", b_flat[(TOT-1)*DW +: DW], b_last);
    @(negedge clk); b_done = 1'b1; b_pred = 32'h12345678;
    @(negedge clk); b_done = 1'b0; b_mready = 1'b1; #1;
    chk("blk_m_valid", b_mvalid, 1);
    chk("blk_m_data", b_mdata, 32'h12345678);
    chk("blk_no_timeout", b_timeout, 0);
    @(negedge clk); b_mready = 1'b0; #1;
    chk("blk_runs", b_runs, 1);
    chk("blk_s_ready", b_sready, 1);
    bsend(TOT - 1);
    chk("blk_no_start_20", b_start, 0);
    repeat (3) @(negedge clk);
    #1 chk("blk_still_fill", b_busy, 0);
    bsend(1);
    chk("blk_start_21", b_start, 1);
    @(negedge clk); b_done = 1'b1;
    @(negedge clk); b_done = 1'b0; b_mready = 1'b1;
    @(negedge clk); b_mready = 1'b0;
  endtask

  initial begin : monitor
    logic [TOT*DW-1:0] w, cur_win;
    cur_win = '0;
    forever begin
      @(negedge clk); #2;
      if (o_start_model) begin
        checks++;
        if (start_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start: got start pulse expected none");
        end else begin
          w = start_q.pop_front();
          cur_win = w;
          if (o_seq_flat !== w) begin
            errors++;
            $display("FAIL window: got %h expected %h", o_seq_flat, w);
          end
        end
      end
      if (o_busy) chk("window_stable", o_seq_flat == cur_win, 1);
      if (m_valid) begin
        if (pred_q.size() == 0) chk("unexpected_m_valid", m_valid, 0);
        else begin
          chk("m_data", m_data, pred_q[0]);
          if (m_ready) w[DW-1:0] = pred_q.pop_front();
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_start", o_start_model, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_runs", o_run_count, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_window", o_seq_flat == '0, 1);
    @(negedge clk); rstn = 1'b1;
    blk_test();
    fill(TOT, 1, 0);
    expect_start();
    finish_run(10, 5, 32'h40490FDB);
    fill(NF, 2, 0);
    expect_start();
    chk("slide_w18", o_seq_flat[18*DW +: DW], 1);
    chk("slide_w19", o_seq_flat[19*DW +: DW], 2);
    chk("slide_w20", o_seq_flat[20*DW +: DW], 3);
    chk("slide_w0", o_seq_flat[0 +: DW], 32'h3F800000);
    finish_run($urandom_range(1, TO), $urandom_range(0, 4), $urandom);
    fill(need, 0, 2);
    expect_start();
    timeout_run();
    repeat (25) begin
      fill(need, 0, 2);
      expect_start();
      if ($urandom_range(0, 3) == 0) timeout_run();
      else finish_run($urandom_range(1, TO), $urandom_range(0, 4), $urandom);
    end
    fill(need, 0, 1);
    expect_start();
    repeat (3) begin
      @(negedge clk); i_model_done = 1'b0;
    end
    @(negedge clk); rstn = 1'b0; #1;
    chk("rstw_s_ready", s_ready, 0);
    chk("rstw_start", o_start_model, 0);
    chk("rstw_m_valid", m_valid, 0);
    chk("rstw_busy", o_busy, 0);
    chk("rstw_timeout", o_timeout, 0);
    @(negedge clk); rstn = 1'b1; i_model_done = 1'b1; i_prediction = $urandom; #1;
    chk("rstw_fill", s_ready, 1);
    @(negedge clk); i_model_done = 1'b0; #1;
    chk("rstw_late_done", m_valid, 0);
    chk("rstw_runs", o_run_count, 0);
    chk("rstw_m_data", m_data, 0);
    chk("rstw_window", o_seq_flat == '0, 1);
    model_reset();
    fill(TOT, 0, 1);
    expect_start();
    finish_run(3, 1, $urandom);
    @(negedge clk); #3;
    chk("start_q_drained", start_q.size(), 0);
    chk("pred_q_drained", pred_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
